// File: rtl/ti_sar_adc_core.sv
// Time-interleaved SAR ADC core: WAYS round-robin bit-serial sub-ADCs
// with per-way offset trim, enable mask, frame snapshot and frame clock.
module ti_sar_adc_core #(
  parameter int WAYS = 16,
  parameter int BITS = 9,
  parameter int IN_W = 12,
  parameter int OS_W = 8
) (
  input  logic                 ADCCLK,
  input  logic                 CLKRST_N,
  input  logic [IN_W-1:0]      ADCIN,
  input  logic [WAYS*OS_W-1:0] OS,
  input  logic [WAYS-1:0]      WAYEN,
  output logic [WAYS*BITS-1:0] ADCOUT,
  output logic [WAYS*BITS-1:0] FRAME,
  output logic                 FRAME_VALID,
  output logic [WAYS-1:0]      BUSY,
  output logic                 CLKOUT_DES
);

  localparam int SW = $clog2(WAYS);
  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int SH = IN_W - BITS;

  if (WAYS % 2 != 0 || WAYS <= BITS || IN_W < BITS) begin : g_bad
    $error("ti_sar_adc_core: illegal WAYS/BITS/IN_W");
  end

  typedef enum logic {IDLE, CONV} state_t;

  state_t          st_q  [WAYS];
  state_t          st_d  [WAYS];
  logic [IW-1:0]   idx_q [WAYS];
  logic [IW-1:0]   idx_d [WAYS];
  logic [BITS-1:0] acc_q [WAYS];
  logic [BITS-1:0] acc_d [WAYS];
  logic [BITS-1:0] tgt_q [WAYS];
  logic [BITS-1:0] tgt_d [WAYS];
  logic [BITS-1:0] out_q [WAYS];
  logic [BITS-1:0] out_d [WAYS];

  logic [SW-1:0]        slot_q, slot_d;
  logic [WAYS*BITS-1:0] frame_q, frame_d;
  logic                 fv_q, fv_d;
  logic                 clk_q, clk_d;
  logic [BITS-1:0]      trial;

  // Saturating offset add, then keep the top BITS of the IN_W code.
  function automatic logic [BITS-1:0] target(
    input logic [IN_W-1:0] x,
    input logic [OS_W-1:0] o
  );
    logic signed [IN_W+1:0] sum;
    logic [IN_W-1:0]        s;
    sum = $signed({2'b00, x}) + (IN_W+2)'($signed(o));
    if (sum < 0) s = '0;
    else if (sum[IN_W]) s = '1;
    else s = sum[IN_W-1:0];
    return BITS'(s >> SH);
  endfunction

  always_comb begin
    slot_d = (slot_q == SW'(WAYS-1)) ? '0 : slot_q + SW'(1);
    trial  = '0;
    for (int k = 0; k < WAYS; k++) begin
      st_d[k]  = st_q[k];
      idx_d[k] = idx_q[k];
      acc_d[k] = acc_q[k];
      tgt_d[k] = tgt_q[k];
      out_d[k] = out_q[k];
      if (st_q[k] == CONV) begin
        trial = acc_q[k] | (BITS'(1) << idx_q[k]);
        if (tgt_q[k] >= trial) acc_d[k] = trial;
        if (idx_q[k] == '0) begin
          out_d[k] = acc_d[k];
          acc_d[k] = '0;
          st_d[k]  = IDLE;
        end else begin
          idx_d[k] = idx_q[k] - IW'(1);
        end
      end else if (slot_q == SW'(k)) begin
        if (WAYEN[k]) begin
          tgt_d[k] = target(ADCIN, OS[k*OS_W +: OS_W]);
          idx_d[k] = IW'(BITS-1);
          acc_d[k] = '0;
          st_d[k]  = CONV;
        end else begin
          out_d[k] = '0;
        end
      end
    end
  end

  always_comb begin
    ADCOUT = '0;
    BUSY   = '0;
    for (int k = 0; k < WAYS; k++) begin
      ADCOUT[k*BITS +: BITS] = out_q[k];
      BUSY[k] = (st_q[k] == CONV);
    end
  end

  always_comb begin
    fv_d    = (slot_q == SW'(WAYS-1));
    frame_d = fv_d ? ADCOUT : frame_q;
    clk_d   = (slot_d < SW'(WAYS/2));
  end

  assign FRAME       = frame_q;
  assign FRAME_VALID = fv_q;
  assign CLKOUT_DES  = clk_q;

  always_ff @(posedge ADCCLK or negedge CLKRST_N) begin
    if (!CLKRST_N) begin
      slot_q  <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      clk_q   <= 1'b0;
      for (int k = 0; k < WAYS; k++) begin
        st_q[k]  <= IDLE;
        idx_q[k] <= '0;
        acc_q[k] <= '0;
        tgt_q[k] <= '0;
        out_q[k] <= '0;
      end
    end else begin
      slot_q  <= slot_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      clk_q   <= clk_d;
      for (int k = 0; k < WAYS; k++) begin
        st_q[k]  <= st_d[k];
        idx_q[k] <= idx_d[k];
        acc_q[k] <= acc_d[k];
        tgt_q[k] <= tgt_d[k];
        out_q[k] <= out_d[k];
      end
    end
  end

endmodule

// File: tb/tb_ti_sar_adc_core.sv
// Directed bench for ti_sar_adc_core: default 16x9-bit instance
// plus a small 8x6-bit instance for the alternate parameter set.
module tb_ti_sar_adc_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [11:0]  adcin;
  logic [127:0] os;
  logic [15:0]  wayen;
  logic [143:0] adcout, frame;
  logic         fv;
  logic [15:0]  busy;
  logic         clkdes;

  logic         rst8_n;
  logic [7:0]   adcin8;
  logic [63:0]  os8;
  logic [7:0]   wayen8;
  logic [47:0]  adcout8, frame8;
  logic         fv8;
  logic [7:0]   busy8;
  logic         clkdes8;

  int n_chk = 0;
  int n_pass = 0;
  int exp_out [16];
  int exp_fr  [16];
  int bcnt;

  always #5 clk = ~clk;

  ti_sar_adc_core #(.WAYS(16), .BITS(9), .IN_W(12), .OS_W(8)) u_dut (
    .ADCCLK(clk), .CLKRST_N(rst_n), .ADCIN(adcin), .OS(os),
    .WAYEN(wayen), .ADCOUT(adcout), .FRAME(frame),
    .FRAME_VALID(fv), .BUSY(busy), .CLKOUT_DES(clkdes)
  );

  ti_sar_adc_core #(.WAYS(8), .BITS(6), .IN_W(8), .OS_W(8)) u_dut8 (
    .ADCCLK(clk), .CLKRST_N(rst8_n), .ADCIN(adcin8), .OS(os8),
    .WAYEN(wayen8), .ADCOUT(adcout8), .FRAME(frame8),
    .FRAME_VALID(fv8), .BUSY(busy8), .CLKOUT_DES(clkdes8)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] way(input int k);
    return 32'(adcout[k*9 +: 9]);
  endfunction

  function automatic logic [31:0] fway(input int k);
    return 32'(frame[k*9 +: 9]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_os(input int k, input logic [7:0] v);
    os[k*8 +: 8] = v;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst8_n = 1'b0;
    adcin  = '0;
    os     = '0;
    wayen  = '1;
    adcin8 = 8'hFF;
    os8    = '0;
    wayen8 = '1;
    tick();
    check("rst_adcout", 32'(|adcout), 32'd0);
    check("rst_frame", 32'(|frame), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fv", 32'(fv), 32'd0);
    check("rst_clkdes", 32'(clkdes), 32'd0);

    // T1: mid-scale input on every way
    adcin = 12'h800;
    rst_n = 1'b1;
    bcnt = 0;
    for (int j = 0; j < 25; j++) begin
      tick();
      if (j < 12 && busy[0]) bcnt++;
    end
    check("t1_busy0_cycles", 32'(bcnt), 32'd9);
    for (int k = 0; k < 16; k++) check("t1_way", way(k), 32'd256);

    // T2: ramp input, frame snapshots
    adcin = '0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      exp_out[k] = 0;
      exp_fr[k]  = 0;
    end
    for (int j = 0; j < 64; j++) begin
      adcin = 12'(j);
      tick();
      if (j % 16 == 15) exp_fr = exp_out;
      if (j >= 9) exp_out[(j-9) % 16] = (j-9) >> 3;
      check("t2_fv", 32'(fv), 32'(j % 16 == 15));
      check("t2_clkdes", 32'(clkdes), 32'((j+1) % 16 < 8));
      if (j >= 9) check("t2_way", way((j-9) % 16), 32'((j-9) >> 3));
      if (j % 16 == 15)
        for (int k = 0; k < 16; k++)
          check("t2_frame", fway(k), 32'(exp_fr[k]));
    end

    // T3: offset trim and saturation
    os = '0;
    set_os(2, 8'hF8);
    set_os(3, 8'd20);
    set_os(5, 8'hEC);
    set_os(6, 8'hF0);
    adcin = '0;
    do_reset();
    for (int j = 0; j < 21; j++) begin
      case (j)
        2: adcin = 12'd2048;
        3: adcin = 12'd4090;
        5: adcin = 12'd5;
        6: adcin = 12'd100;
        default: adcin = 12'd0;
      endcase
      tick();
    end
    check("t3_way2", way(2), 32'd255);
    check("t3_way3", way(3), 32'd511);
    check("t3_way5", way(5), 32'd0);
    check("t3_way6", way(6), 32'd10);

    // T4: disable way 4 mid-conversion
    os = '0;
    adcin = 12'h800;
    wayen = '1;
    do_reset();
    for (int j = 0; j < 21; j++) begin
      if (j == 6) wayen[4] = 1'b0;
      tick();
      if (j == 12) check("t4_busy_mid", 32'(busy[4]), 32'd1);
      if (j == 13) check("t4_done", way(4), 32'd256);
      if (j == 13) check("t4_busy_end", 32'(busy[4]), 32'd0);
      if (j == 19) check("t4_hold", way(4), 32'd256);
      if (j == 20) check("t4_zero", way(4), 32'd0);
    end

    // T5: async reset mid-frame
    wayen = '1;
    do_reset();
    for (int j = 0; j < 11; j++) tick();
    check("t5_busy_pre", 32'(busy[10:2]), 32'h1FF);
    check("t5_way1_pre", way(1), 32'd256);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_adcout", 32'(|adcout), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_clkdes", 32'(clkdes), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_restart_busy", 32'(busy), 32'h0001);
    check("t5_restart_clk", 32'(clkdes), 32'd1);
    for (int j = 1; j < 10; j++) tick();
    check("t5_way0", way(0), 32'd256);

    // T6: 8-way 6-bit instance
    rst8_n = 1'b1;
    for (int j = 0; j < 24; j++) begin
      tick();
      check("t6_clkdes", 32'(clkdes8), 32'((j+1) % 8 < 4));
      if (j == 6) check("t6_way0", 32'(adcout8[5:0]), 32'd63);
    end
    for (int k = 0; k < 8; k++)
      check("t6_way", 32'(adcout8[k*6 +: 6]), 32'd63);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
